// File: rtl/dm_pkg.sv
// dm_pkg: shared store-width codes, buffered-entry layout and byte-mask helper
//   BT_W/BT_H/BT_B : bit_type encodings for SW, SH and SB
//   entry_t        : word address, lane-aligned write data, byte enables
//   be_mask        : expands byte enables to a 32-bit lane mask
package dm_pkg;
    localparam logic [2:0] BT_W = 3'b000;
    localparam logic [2:0] BT_H = 3'b001;
    localparam logic [2:0] BT_B = 3'b010;
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/dm_store_buf_align.sv
// store_align: combinational store alignment, byte enables and legality
//   addr     in  : byte address of the store
//   bit_type in  : store width code (BT_W/BT_H/BT_B, others illegal)
//   data     in  : rt value, payload in the low bits
//   ent      out : word address, lane-aligned data (unused lanes 0), byte enables
//   legal    out : width code known and address naturally aligned
module store_align import dm_pkg::*; (
    input  logic [31:0] addr,
    input  logic [2:0]  bit_type,
    input  logic [31:0] data,
    output entry_t      ent,
    output logic        legal
);
    always_comb begin
        ent.addr  = addr[31:2];
        legal     = (bit_type == BT_W && addr[1:0] == 2'b00) || (bit_type == BT_H && !addr[0]) || bit_type == BT_B;
        ent.be    = bit_type == BT_W ? 4'b1111 : bit_type == BT_H ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        ent.wdata = bit_type == BT_W ? data : bit_type == BT_H ? (addr[1] ? {data[15:0], 16'h0} : {16'h0, data[15:0]}) : {24'h0, data[7:0]} << {addr[1:0], 3'b000};
    end
endmodule

// File: rtl/dm_store_buf.sv
// dm_store_buf: DEPTH-entry store buffer between the pipeline and data memory
//   clk, reset(active-low async)
//   st_valid/st_ready, st_addr, bit_type, st_data : store request from the pipeline
//   mem_req/mem_gnt, mem_addr, mem_wdata, mem_be  : head entry write to data memory
//   ld_addr/ld_hit : load word address matches a pending entry
//   empty, err (one-cycle pulse on dropped illegal store), err_addr
//   Optional DM_STORE_MERGE_EN: same-word stores merge into the tail entry.
module dm_store_buf import dm_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [2:0]  bit_type,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty,
    output logic        err,
    output logic [31:0] err_addr
);
    localparam int PW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    entry_t ent, head;
    logic [PW-1:0] wp, rp, tp;
    logic [PW:0] count;
    logic [DEPTH-1:0] live;
    logic legal, merge, accept, push, pop;
    logic unused;
    store_align u_align (
        .addr(st_addr),
        .bit_type(bit_type),
        .data(st_data),
        .ent(ent),
        .legal(legal)
    );
    assign tp = wp - PW'(1);
`ifdef DM_STORE_MERGE_EN
    // With two or more entries the tail is never the head, so it cannot be mid-grant.
    assign merge = legal && count >= (PW+1)'(2) && mem[tp].addr == ent.addr;
`else
    assign merge = 1'b0;
`endif
    assign st_ready = count != (PW+1)'(DEPTH) || merge;
    assign accept = st_valid && st_ready;
    assign push = accept && legal && !merge;
    assign pop = mem_req && mem_gnt;
    assign head = mem[rp];
    assign mem_req = count != '0;
    assign empty = count == '0;
    assign mem_addr = {head.addr, 2'b00};
    assign mem_wdata = head.wdata;
    assign mem_be = head.be;
    assign unused = &{1'b0, ld_addr[1:0]};
    // Slot g holds a pending entry when its distance from the head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        assign live[g] = {1'b0, PW'(g) - rp} < count;
    end
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ld_hit = ld_hit | (live[i] && mem[i].addr == ld_addr[31:2]);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            err   <= accept && !legal;
            if (accept && !legal) err_addr <= st_addr;
        end
    end
    // New lanes of a merged store overwrite the tail; its other lanes are kept.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= ent;
        else if (accept && merge) mem[tp] <= '{addr: ent.addr, wdata: (mem[tp].wdata & ~be_mask(ent.be)) | ent.wdata, be: mem[tp].be | ent.be};
    end
endmodule

// File: doc/dm_store_buf.md
DM_STORE_BUF -- requirements
Module: dm_store_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered store entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  meaning the single clock, with all state on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port st_valid  input  1  meaning the pipeline presents a store.
REQ-005 SHALL have port st_ready  output  1  meaning the buffer accepts the presented store this cycle.
REQ-006 SHALL have port st_addr  input  32  meaning the byte address of the store.
REQ-007 SHALL have port bit_type  input  3  meaning store width: 000 SW, 001 SH, 010 SB, others illegal.
REQ-008 SHALL have port st_data  input  32  meaning rt register value, with the payload in its low bits.
REQ-009 SHALL have port mem_req  output  1  meaning a head entry is presented to data memory.
REQ-010 SHALL have port mem_gnt  input  1  meaning data memory takes the presented write this cycle.
REQ-011 SHALL have ports mem_addr  output  32, mem_wdata  output  32 and mem_be  output  4, meaning word-aligned address (bits [1:0]=00), lane-aligned data and byte enables.
REQ-012 SHALL have ports ld_addr  input  32 and ld_hit  output  1, meaning a load word address matches a pending entry.
REQ-013 SHALL have ports empty  output  1 and err  output  1, meaning no pending entries, and a one-cycle pulse on a dropped illegal store.
REQ-014 SHALL have port err_addr  output  32  meaning st_addr of the last dropped store.

Function
REQ-015 SHALL drive st_ready=1 when count<DEPTH and 0 otherwise; accept = st_valid&&st_ready.
REQ-016 SHALL align SW as BE 1111 with wdata=st_data.
REQ-017 SHALL align SH as addr[1]=0: BE 0011, wdata[15:0]=st_data[15:0]; addr[1]=1: BE 1100, wdata[31:16]=st_data[15:0].
REQ-018 SHALL align SB as addr[1:0]=n: BE bit n set, st_data[7:0] on byte lane n; unused lanes shall be 0.
REQ-019 SHALL treat SW with addr[1:0]!=00, SH with addr[0]=1, and bit_type 011..111 as illegal: consume (st_ready rules unchanged), do not enqueue, pulse err on the next cycle, and load err_addr.
REQ-020 SHALL make an accepted legal store visible on mem_req no earlier than the next cycle (one-cycle latency when empty).
REQ-021 SHALL keep mem_req high while count>0, with mem_addr/mem_wdata/mem_be equal to the head entry and stable until mem_req&&mem_gnt.
REQ-022 SHALL pop the head on mem_req&&mem_gnt.
REQ-023 SHALL allow push and pop in the same cycle; count unchanged, FIFO order preserved.
REQ-024 SHALL not pass through when full, even if mem_gnt=1 that cycle.
REQ-025 SHALL compute ld_hit combinationally: 1 if any valid entry (including the head) has addr[31:2]==ld_addr[31:2]; entries being accepted this cycle are excluded.
REQ-026 SHALL wrap read/write pointers modulo DEPTH and drive empty=(count==0).

Reset
REQ-027 SHALL, on reset low, immediately clear count and pointers, drive mem_req=0, err=0, err_addr=0, empty=1; pending stores are discarded.
REQ-028 SHALL take effect identically when reset asserts mid-transfer (mem_req high, no grant); no write completes.

Configuration
REQ-029 SHALL support macro DM_STORE_MERGE_EN; when defined, a legal store whose word address equals the tail entry, with count>=2 (tail not at head), SHALL merge into the tail (BE OR, new bytes overwrite) without consuming a slot, with st_ready=1 even when full.
REQ-030 SHALL, when DM_STORE_MERGE_EN is undefined, enqueue every legal store separately.

Structure
REQ-031 SHALL place in shared package dm_pkg: bit_type constants BT_W/BT_H/BT_B, and entry typedef {addr[31:2], wdata, be}.
REQ-032 SHALL implement alignment, BE and legality in combinational sub-module store_align; the FIFO, handshake and hit logic remain in dm_store_buf.

Verification
REQ-033 SHALL verify SB addr 0x1003, data 0x000000AB, mem_gnt=1 -> next cycle mem_req=1, mem_addr 0x1000, mem_be 1000, mem_wdata 0xAB000000.
REQ-034 SHALL verify SH addr 0x2002 data 0x1234 with mem_gnt=0 for 3 cycles -> outputs stable 0x12340000/BE 1100 throughout; pop on gnt, empty=1 next cycle.
REQ-035 SHALL verify SW 0x3001 -> not enqueued, err=1 one cycle, err_addr=0x3001, empty stays 1.
REQ-036 SHALL verify two stores with mem_gnt=0 (DEPTH=2) -> st_ready=0; third store held; ld_addr 0x1000 with an entry at 0x1002 -> ld_hit=1.
REQ-037 SHALL verify reset asserted with 2 entries pending -> mem_req=0 asynchronously, no write seen after release.
REQ-038 SHALL verify, with DM_STORE_MERGE_EN, full buffer with tail 0x4000 BE 0001, then SB 0x4001 data 0xCD -> accepted, tail BE 0011, count stays 2.
